// File: rtl/riscv_icache_ctrl.sv
// Instruction cache miss/refill controller: refills the primary block and, for
// straddling fetches, the following block, then updates the tag array.
module riscv_icache_ctrl #(
    parameter int IDX    = 12,
    parameter int TAG    = 9,
    parameter int BEATS  = 4,
    parameter int BEAT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              fetch_missalign,
    input  logic [TAG-1:0]    fetch_tag,
    input  logic [IDX-1:0]    fetch_index,
    input  logic              hit,
    input  logic              hit_missalign,
    output logic [TAG-1:0]    tag_tag,
    output logic [IDX-1:0]    tag_index,
    output logic [TAG-1:0]    tag_tag_nxt,
    output logic [IDX-1:0]    tag_index_nxt,
    output logic              replace_tag,
    output logic              valid_in,
    output logic              replace_tag_align,
    output logic              valid_in_align,
    output logic              mem_req,
    output logic [TAG+IDX-1:0] mem_addr,
    input  logic              mem_valid,
    output logic              data_we,
    output logic [IDX-1:0]    data_index,
    output logic [BEAT_W-1:0] data_beat,
    output logic              stall,
    output logic              busy
);

    localparam int AW = TAG + IDX;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REFILL_A = 3'd1,
        UPD_A    = 3'd2,
        REFILL_B = 3'd3,
        UPD_B    = 3'd4
    } state_t;

    state_t            state;
    logic [TAG-1:0]    tag_lat;
    logic [IDX-1:0]    index_lat;
    logic              missalign_lat;
    logic [BEAT_W-1:0] beat_cnt;
    logic [AW-1:0]     cur_blk;
    logic [AW-1:0]     nxt_blk;
    logic              ok;
    logic              refilling;
    logic              last_beat;

    // Block address source: live fetch address while idle, latched miss address otherwise
    always_comb begin
        cur_blk = {tag_lat, index_lat};
        if (state == IDLE) begin
            cur_blk = {fetch_tag, fetch_index};
        end else begin
            cur_blk = {tag_lat, index_lat};
        end
        nxt_blk = cur_blk + {{(AW-1){1'b0}}, 1'b1};
    end

    assign tag_tag       = cur_blk[AW-1:IDX];
    assign tag_index     = cur_blk[IDX-1:0];
    assign tag_tag_nxt   = nxt_blk[AW-1:IDX];
    assign tag_index_nxt = nxt_blk[IDX-1:0];

    assign refilling = (state == REFILL_A) || (state == REFILL_B);
    assign last_beat = (beat_cnt == BEAT_W'(BEATS-1));
    assign ok        = hit && (!fetch_missalign || hit_missalign);

    // Memory-side addressing, data array write strobe and fetch stall
    always_comb begin
        mem_addr   = cur_blk;
        data_index = index_lat;
        if (state == REFILL_B) begin
            mem_addr   = nxt_blk;
            data_index = nxt_blk[IDX-1:0];
        end else begin
            mem_addr   = cur_blk;
            data_index = index_lat;
        end
        data_we   = refilling && mem_valid;
        data_beat = beat_cnt;
        if (state == IDLE) begin
            stall = fetch_req && !ok;
        end else begin
            stall = 1'b1;
        end
    end

    // Refill FSM with registered strobes; busy and mem_req track the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            beat_cnt          <= {BEAT_W{1'b0}};
            tag_lat           <= {TAG{1'b0}};
            index_lat         <= {IDX{1'b0}};
            missalign_lat     <= 1'b0;
            mem_req           <= 1'b0;
            replace_tag       <= 1'b0;
            valid_in          <= 1'b0;
            replace_tag_align <= 1'b0;
            valid_in_align    <= 1'b0;
            busy              <= 1'b0;
        end else begin
            replace_tag       <= 1'b0;
            valid_in          <= 1'b0;
            replace_tag_align <= 1'b0;
            valid_in_align    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req && !hit) begin
                        tag_lat       <= fetch_tag;
                        index_lat     <= fetch_index;
                        missalign_lat <= fetch_missalign;
                        state         <= REFILL_A;
                        mem_req       <= 1'b1;
                        busy          <= 1'b1;
                    end else if (fetch_req && fetch_missalign && !hit_missalign) begin
                        tag_lat       <= fetch_tag;
                        index_lat     <= fetch_index;
                        missalign_lat <= fetch_missalign;
                        state         <= REFILL_B;
                        mem_req       <= 1'b1;
                        busy          <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                REFILL_A, REFILL_B: begin
                    if (mem_valid) begin
                        if (last_beat) begin
                            beat_cnt <= {BEAT_W{1'b0}};
                            mem_req  <= 1'b0;
                            if (state == REFILL_A) begin
                                state       <= UPD_A;
                                replace_tag <= 1'b1;
                                valid_in    <= 1'b1;
                            end else begin
                                state             <= UPD_B;
                                replace_tag_align <= 1'b1;
                                valid_in_align    <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + {{(BEAT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state <= state;
                    end
                end
                UPD_A: begin
                    // The next block sits at another index, so hit_missalign is stable here
                    if (missalign_lat && !hit_missalign) begin
                        state   <= REFILL_B;
                        mem_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                UPD_B: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_req  <= 1'b0;
                    beat_cnt <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
